// File: rtl/mac_pkg.sv
// mac_pkg: shared definitions for the multi-lane MAC dot-product engine.
//   - state_e     : engine FSM states
//   - *_DEF       : default parameter values for the engine and lane tree
//   - lane_sum_w  : width of one beat's lane sum (product width + tree growth)
package mac_pkg;

  localparam int LANES_DEF    = 4;
  localparam int DATA_W_DEF   = 8;
  localparam int WEIGHT_W_DEF = 8;
  localparam int ACC_W_DEF    = 32;
  localparam int LEN_W_DEF    = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  // Sum of LANES unsigned products never needs more than $clog2(LANES)
  // extra bits on top of the product width.
  function automatic int lane_sum_w(input int data_w, input int weight_w,
                                    input int lanes);
    return data_w + weight_w + $clog2(lanes);
  endfunction

endpackage

// File: rtl/mac_lane_tree.sv
// mac_lane_tree: stage 1 of the MAC pipeline. LANES unsigned multipliers
// feeding an adder tree whose result is registered on every accepted beat.
// Ports:
//   clock, reset   : rising-edge clock, synchronous active-high reset
//   in_valid       : beat accepted by the engine this cycle
//   data_in        : LANES x DATA_W activations, lane i at [i*DATA_W +: DATA_W]
//   weight_in      : LANES x WEIGHT_W weights, same packing
//   sum_out        : registered lane sum of the last accepted beat
//   sum_valid      : sum_out holds a beat not yet accumulated
module mac_lane_tree
  import mac_pkg::*;
#(
  parameter int LANES    = LANES_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int WEIGHT_W = WEIGHT_W_DEF,
  localparam int SUM_W   = lane_sum_w(DATA_W, WEIGHT_W, LANES)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [LANES*DATA_W-1:0]   data_in,
  input  logic [LANES*WEIGHT_W-1:0] weight_in,
  output logic [SUM_W-1:0]          sum_out,
  output logic                      sum_valid
);

  localparam int PROD_W = DATA_W + WEIGHT_W;

  logic [SUM_W-1:0] sum_d, sum_q;
  logic             valid_d, valid_q;
  logic [SUM_W-1:0] tree_sum;

  always_comb begin
    // NOTE: every combinational output gets a default before any branch or
    // loop, so no path leaves it unassigned and no latch is inferred.
    tree_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      tree_sum = tree_sum + SUM_W'(PROD_W'(data_in[i*DATA_W +: DATA_W]) *
                                  PROD_W'(weight_in[i*WEIGHT_W +: WEIGHT_W]));
    end
    // Only a real beat reloads the register; idle cycles hold it.
    sum_d   = in_valid ? tree_sum : sum_q;
    valid_d = in_valid;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge inputs regardless of block ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      sum_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      valid_q <= valid_d;
    end
  end

  assign sum_out   = sum_q;
  assign sum_valid = valid_q;

endmodule

// File: rtl/mac_dot_engine.sv
// mac_dot_engine: multi-lane unsigned dot-product engine. Accumulates
// `length` beats of LANES activation/weight pairs and presents the result on
// a valid/ready port. Requires ACC_W >= DATA_W+WEIGHT_W+$clog2(LANES).
// Optional build macro: MAC_SATURATE_EN -- accumulator clamps at 2^ACC_W-1
// and raises overflow; when undefined the accumulator wraps and overflow=0.
// Ports:
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   start, length         : begin a dot product of `length` beats (IDLE only)
//   in_valid, in_ready    : input beat handshake (ready only in ACCUM)
//   data_in, weight_in    : packed lane operands, lane i in the low-order slot i
//   out_valid, out_ready  : result handshake
//   acc_out, overflow     : result and clamp flag, stable while out_valid
//   busy                  : engine not idle
module mac_dot_engine
  import mac_pkg::*;
#(
  parameter int LANES    = LANES_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int WEIGHT_W = WEIGHT_W_DEF,
  parameter int ACC_W    = ACC_W_DEF,
  parameter int LEN_W    = LEN_W_DEF
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [LEN_W-1:0]          length,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   data_in,
  input  logic [LANES*WEIGHT_W-1:0] weight_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACC_W-1:0]          acc_out,
  output logic                      overflow,
  output logic                      busy
);

  localparam int SUM_W = lane_sum_w(DATA_W, WEIGHT_W, LANES);

  state_e           state_d, state_q;
  logic [LEN_W-1:0] remaining_d, remaining_q;
  logic [ACC_W-1:0] acc_d, acc_q;
  logic [SUM_W-1:0] lane_sum;
  logic             lane_valid;
  logic             beat_accept;

  assign in_ready    = (state_q == ST_ACCUM);
  assign beat_accept = in_valid && in_ready;

  mac_lane_tree #(
    .LANES    (LANES),
    .DATA_W   (DATA_W),
    .WEIGHT_W (WEIGHT_W)
  ) u_lane_tree (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (beat_accept),
    .data_in   (data_in),
    .weight_in (weight_in),
    .sum_out   (lane_sum),
    .sum_valid (lane_valid)
  );

`ifdef MAC_SATURATE_EN
  logic             ovf_d, ovf_q;
  // One extra bit exposes the carry out of the accumulator.
  logic [ACC_W:0]   acc_sum;
  assign acc_sum = {1'b0, acc_q} + {1'b0, ACC_W'(lane_sum)};
`else
  logic [ACC_W-1:0] acc_sum;
  assign acc_sum = acc_q + ACC_W'(lane_sum);
`endif

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    acc_d       = acc_q;
`ifdef MAC_SATURATE_EN
    ovf_d       = ovf_q;
`endif

    // Stage 2: only a valid stage-1 beat touches the accumulator.
    if (lane_valid) begin
`ifdef MAC_SATURATE_EN
      if (acc_sum[ACC_W]) begin
        acc_d = '1;
        ovf_d = 1'b1;
      end else begin
        acc_d = acc_sum[ACC_W-1:0];
      end
`else
      acc_d = acc_sum;
`endif
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d = '0;
`ifdef MAC_SATURATE_EN
          ovf_d = 1'b0;
`endif
          if (length != '0) begin
            remaining_d = length;
            state_d     = ST_ACCUM;
          end else begin
            state_d = ST_OUT;
          end
        end
      end
      ST_ACCUM: begin
        if (beat_accept) begin
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == LEN_W'(1)) state_d = ST_DRAIN;
        end
      end
      // The last beat is still in stage 1 on the first DRAIN cycle; leave
      // once it has been folded into the accumulator.
      ST_DRAIN: begin
        if (!lane_valid) state_d = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      acc_q       <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      acc_q       <= acc_d;
    end
  end

`ifdef MAC_SATURATE_EN
  always_ff @(posedge clock) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end
  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

  assign out_valid = (state_q == ST_OUT);
  assign acc_out   = acc_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mac_dot_engine.sv
// Directed testbench for mac_dot_engine: a default-width instance (ACC_W=32)
// and a narrow instance (ACC_W=18) share all inputs; expected values are
// hand-computed constants.
module tb_mac_dot_engine;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  length = '0;
  logic        in_valid = 1'b0;
  logic [31:0] data_in = '0;
  logic [31:0] weight_in = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, overflow, busy;
  logic [31:0] acc_out;
  logic        s_in_ready, s_out_valid, s_overflow, s_busy;
  logic [17:0] s_acc_out;

  int checks = 0;
  int errors = 0;
  int lat;

  localparam logic [31:0] V42  = 32'd42;
  localparam logic [31:0] W12  = 32'd12;
  localparam logic [31:0] FULL = 32'hFFFF_FFFF;

`ifdef MAC_SATURATE_EN
  localparam logic [17:0] SAT_ACC = 18'd262143;
  localparam logic        SAT_OVF = 1'b1;
`else
  localparam logic [17:0] SAT_ACC = 18'd258056;
  localparam logic        SAT_OVF = 1'b0;
`endif

  always #5 clock = ~clock;

  mac_dot_engine u_dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .length    (length),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .weight_in (weight_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_out   (acc_out),
    .overflow  (overflow),
    .busy      (busy)
  );

  mac_dot_engine #(.ACC_W(18)) u_narrow (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .length    (length),
    .in_valid  (in_valid),
    .in_ready  (s_in_ready),
    .data_in   (data_in),
    .weight_in (weight_in),
    .out_valid (s_out_valid),
    .out_ready (out_ready),
    .acc_out   (s_acc_out),
    .overflow  (s_overflow),
    .busy      (s_busy)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic start_run(input logic [9:0] len);
    start  = 1'b1;
    length = len;
    step();
    start  = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic [31:0] w, input int n);
    in_valid  = 1'b1;
    data_in   = d;
    weight_in = w;
    repeat (n) step();
    in_valid  = 1'b0;
  endtask

  // Bounded wait for out_valid; n counts edges since the call.
  task automatic wait_out(input string tag, output int n);
    n = 0;
    while (!out_valid && n < 16) begin
      step();
      n++;
    end
    check({tag, "_out_valid"}, out_valid, 1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    step();
    step();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_acc_out", acc_out, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);
    check("rst_narrow_busy", s_busy, 0);
    reset = 1'b0;
    step();

    // Single beat 42*12, exact 2-cycle latency
    start_run(10'd1);
    check("one_busy", busy, 1);
    check("one_in_ready", in_ready, 1);
    send(V42, W12, 1);
    check("one_drain_in_ready", in_ready, 0);
    check("one_t0_out_valid", out_valid, 0);
    step();
    check("one_t1_out_valid", out_valid, 0);
    step();
    check("one_t2_out_valid", out_valid, 1);
    check("one_acc", acc_out, 504);
    check("one_overflow", overflow, 0);
    handshake();
    check("one_done_out_valid", out_valid, 0);
    check("one_done_busy", busy, 0);

    // Full scale, 4 beats
    start_run(10'd4);
    send(FULL, FULL, 4);
    wait_out("full", lat);
    check("full_latency", lat, 2);
    check("full_acc", acc_out, 1040400);
    handshake();

    // Input gaps, then output backpressure for 5 cycles
    start_run(10'd4);
    data_in   = FULL;
    weight_in = FULL;
    for (int i = 0; i < 8; i++) begin
      in_valid = (i % 2 == 0);
      step();
    end
    in_valid = 1'b0;
    wait_out("gap", lat);
    check("gap_acc", acc_out, 1040400);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_out_valid", out_valid, 1);
      check("bp_acc", acc_out, 1040400);
      check("bp_busy", busy, 1);
    end
    handshake();
    check("bp_done_busy", busy, 0);
    check("bp_done_out_valid", out_valid, 0);

    // Zero length; start during OUT must be ignored
    start_run(10'd0);
    check("zero_out_valid", out_valid, 1);
    check("zero_acc", acc_out, 0);
    check("zero_overflow", overflow, 0);
    start_run(10'd3);
    check("zero_ign_out_valid", out_valid, 1);
    check("zero_ign_in_ready", in_ready, 0);
    handshake();
    check("zero_done_busy", busy, 0);
    step();
    check("zero_idle_busy", busy, 0);
    check("zero_idle_in_ready", in_ready, 0);

    // Two full-scale beats: narrow accumulator wraps or clamps
    start_run(10'd2);
    send(FULL, FULL, 2);
    wait_out("narrow", lat);
    check("narrow_out_valid", s_out_valid, 1);
    check("narrow_acc", s_acc_out, SAT_ACC);
    check("narrow_overflow", s_overflow, SAT_OVF);
    check("wide_acc", acc_out, 520200);
    check("wide_overflow", overflow, 0);
    handshake();

    // Reset after 3 of 8 beats, then a clean single-beat run
    start_run(10'd8);
    send(V42, W12, 3);
    check("mid_in_ready_pre", s_in_ready, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_in_ready", in_ready, 0);
    check("mid_out_valid", out_valid, 0);
    check("mid_busy", busy, 0);
    check("mid_acc", acc_out, 0);
    start_run(10'd1);
    send(V42, W12, 1);
    wait_out("post", lat);
    check("post_latency", lat, 2);
    check("post_acc", acc_out, 504);
    check("post_narrow_acc", s_acc_out, 504);
    check("post_narrow_overflow", s_overflow, 0);
    handshake();
    check("post_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_dot_engine.md
# mac_dot_engine

Parametrised multi-lane successor to the single-lane uint8 × uint8 → int32 MAC used by the tiny-CNN datapath. Each beat consumes LANES activation/weight pairs. The block accumulates a programmable number of beats (one conv kernel window or FC row), then presents the dot product on a valid/ready output port. It sits between the line-buffer/weight-ROM feeders and the requantise/ReLU stage on the Basys3 build.

## Interface
- LANES, 4, activation/weight pairs per beat (≥1)
- DATA_W, 8, unsigned activation width
- WEIGHT_W, 8, unsigned weight width
- ACC_W, 32, accumulator width; must be ≥ DATA_W+WEIGHT_W+$clog2(LANES)
- LEN_W, 10, width of beat-count field
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin new dot product; sampled only in IDLE
- length  in  LEN_W  beats to accumulate, captured with start
- in_valid  in  1  input beat valid
- in_ready  out  1  engine accepts beat
- data_in  in  LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W]
- weight_in  in  LANES*WEIGHT_W  same packing
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- acc_out  out  ACC_W  dot-product result
- overflow  out  1  accumulator clamped during this result
- busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, ACCUM, DRAIN, OUT.
- IDLE: in_ready=0. On start with length≠0: capture length into remaining counter, clear accumulator and overflow, go to ACCUM. On start with length=0: clear accumulator and overflow, go to OUT.
- ACCUM: in_ready=1. Each in_valid&&in_ready beat decrements remaining. The beat that brings remaining to 0 moves the FSM to DRAIN. in_ready is 0 from DRAIN onward.
- DRAIN: waits for the pipeline to empty (fixed 1 cycle), then goes to OUT.
- OUT: out_valid=1; acc_out and overflow held stable until out_ready; on handshake go to IDLE.
- start outside IDLE is ignored.
- Arithmetic: all operands unsigned. Product width is DATA_W+WEIGHT_W. The lane sum is zero-extended to ACC_W and added to the accumulator. Without saturation the sum wraps modulo 2^ACC_W.
- reset at any point: FSM→IDLE, accumulator, counter, pipeline valid and overflow cleared. Any in-flight result is discarded.
- Reset values: in_ready=0, out_valid=0, acc_out=0, overflow=0, busy=0.

## Timing
- Stage 1 (edge of accepted beat): lane products and adder tree registered.
- Stage 2 (next edge): accumulator updated.
- Last beat accepted at edge T: DRAIN during cycle T..T+1, out_valid high after edge T+2.
- Latency from the last beat to out_valid is 2 cycles, independent of LANES.
- length=0: out_valid high 1 cycle after the start edge, acc_out=0.
- Input gaps (in_valid=0) cost cycles only. The pipeline stage-1 valid bit gates accumulation.
- Minimum one IDLE cycle between the out handshake and the next accepted start.
- Throughput is one beat/cycle in ACCUM.

## Configuration
- MAC_SATURATE_EN defined: accumulation clamps at 2^ACC_W−1. overflow is set on the first clamp and stays set until the next start or reset.
- MAC_SATURATE_EN undefined: accumulation wraps; overflow is tied to 0.

## Structure
- Package mac_pkg:
  - FSM state enum.
  - Default width localparams.
  - Function computing the lane-sum width.
- Sub-module mac_lane_tree: LANES multipliers plus a registered adder tree (stage 1), parametrised identically.
- The top holds the FSM, counter, accumulator and output register.

## Test plan
- Single beat, LANES=4, length=1: data {42,0,0,0}, weights {12,0,0,0} → acc_out=504, out_valid 2 cycles after the beat, overflow=0.
- Full-scale, length=4: all lanes 255×255 → acc_out=1040400.
- Backpressure, same vectors as the full-scale case:
  - in_valid alternating 1/0 → acc_out still 1040400.
  - out_ready held low 5 cycles → out_valid and acc_out stable throughout; busy drops after the handshake.
- Zero length: start with length=0 → out_valid next cycle, acc_out=0; start during OUT ignored.
- ACC_W=18, two full-scale beats:
  - With MAC_SATURATE_EN → acc_out=262143, overflow=1.
  - Without → acc_out=258056, overflow=0.
- Reset mid-operation: reset after 3 of 8 beats → in_ready=0, out_valid=0, busy=0 next cycle. A following length=1 run {42×12} returns 504.
